// File: rtl/graph_mem_arbiter.sv
`timescale 1ns/1ps
// graph_mem_arbiter
// Shares one in-order graph_memory read port among NUM_REQ requesters.
// A round-robin arbiter grants one request per cycle while fewer than
// MAX_OUT reads are outstanding. A tag FIFO remembers which requester owns
// each outstanding read, so every in-order return is routed to its owner.
// A RUN/DRAIN state machine lets the system stop issuing and empty the pipe.
//
// Ports
//   clk_in          clock, rising edge
//   rst_in          asynchronous active-high reset
//   req_valid_in    per-requester read request
//   req_addr_in     per-requester read address (unpacked, 32 bits each)
//   req_ready_out   combinational grant, at most one bit set
//   resp_valid_out  registered one-hot response strobe
//   resp_data_out   registered response data (shared)
//   mem_req_out     registered address to memory
//   mem_valid_out   registered read strobe to memory
//   mem_data_in     read data from memory
//   mem_valid_in    read data valid (returns are in order)
//   drain_in        level request to stop issuing
//   drained_out     high while draining with nothing outstanding
//   busy_out        high while any read is outstanding
//   err_out         sticky: a return arrived with nothing outstanding
module graph_mem_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MAX_OUT = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [NUM_REQ-1:0] req_valid_in,
    input  logic [31:0]        req_addr_in [NUM_REQ],
    output logic [NUM_REQ-1:0] req_ready_out,
    output logic [NUM_REQ-1:0] resp_valid_out,
    output logic [31:0]        resp_data_out,
    output logic [31:0]        mem_req_out,
    output logic               mem_valid_out,
    input  logic [31:0]        mem_data_in,
    input  logic               mem_valid_in,
    input  logic               drain_in,
    output logic               drained_out,
    output logic               busy_out,
    output logic               err_out
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]   MAX_CNT  = CNT_W'(MAX_OUT);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_next_s;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [IDX_W-1:0]   tag_fifo_r [MAX_OUT];

    logic               grant_found_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic [NUM_REQ-1:0] grant_s;
    logic               push_s;
    logic               pop_s;
    logic               orphan_s;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        cand          = 0;
        cand_idx      = '0;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        grant_s       = '0;
        if ((state_r == ST_RUN) && (count_r < MAX_CNT)) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand     = (int'(rr_ptr_r) + k) % NUM_REQ;
                cand_idx = IDX_W'(cand);
                if (!grant_found_s && req_valid_in[cand_idx]) begin
                    grant_found_s = 1'b1;
                    grant_idx_s   = cand_idx;
                end else begin
                    grant_found_s = grant_found_s;
                end
            end
        end else begin
            grant_found_s = 1'b0;
        end
        if (grant_found_s) begin
            grant_s = ONE_HOT0 << grant_idx_s;
        end else begin
            grant_s = '0;
        end
    end

    assign req_ready_out = grant_s;
    // A grant is only ever given to a valid requester, so grant == handshake.
    assign push_s   = grant_found_s;
    assign pop_s    = mem_valid_in && (count_r != {CNT_W{1'b0}});
    assign orphan_s = mem_valid_in && (count_r == {CNT_W{1'b0}});
    assign busy_out = (count_r != {CNT_W{1'b0}});

    // Next outstanding count and next state.
    always_comb begin
        count_next_s = count_r;
        state_next_s = state_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
        case (state_r)
            ST_RUN:   state_next_s = drain_in ? ST_DRAIN : ST_RUN;
            ST_DRAIN: state_next_s = drain_in ? ST_DRAIN : ST_RUN;
            default:  state_next_s = ST_RUN;
        endcase
    end

    // State machine, tag FIFO and all registered outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r        <= ST_RUN;
            rr_ptr_r       <= LAST_IDX;
            count_r        <= '0;
            wr_ptr_r       <= '0;
            rd_ptr_r       <= '0;
            for (int i = 0; i < MAX_OUT; i++) begin
                tag_fifo_r[i] <= '0;
            end
            mem_valid_out  <= 1'b0;
            mem_req_out    <= 32'h0000_0000;
            resp_valid_out <= '0;
            resp_data_out  <= 32'h0000_0000;
            err_out        <= 1'b0;
            drained_out    <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            count_r     <= count_next_s;
            // Mirrors state/count in the same cycle they become visible.
            drained_out <= (state_next_s == ST_DRAIN) && (count_next_s == {CNT_W{1'b0}});
            err_out     <= err_out | orphan_s;

            if (push_s) begin
                rr_ptr_r             <= grant_idx_s;
                tag_fifo_r[wr_ptr_r] <= grant_idx_s;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
                mem_valid_out        <= 1'b1;
                mem_req_out          <= req_addr_in[grant_idx_s];
            end else begin
                mem_valid_out        <= 1'b0;
            end

            if (pop_s) begin
                rd_ptr_r       <= rd_ptr_r + PTR_W'(1);
                resp_valid_out <= ONE_HOT0 << tag_fifo_r[rd_ptr_r];
                resp_data_out  <= mem_data_in;
            end else begin
                resp_valid_out <= '0;
            end
        end
    end

endmodule
